// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared definitions for the vector-register read sequencer:
//               read-select encodings, sequencer state type, default widths
//               and small read-select decode helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_OPC_W  = 5;

  localparam logic [1:0] RSEL_BOTH = 2'b00;
  localparam logic [1:0] RSEL_R2   = 2'b01;
  localparam logic [1:0] RSEL_R3   = 2'b10;
  localparam logic [1:0] RSEL_NONE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE_A = 3'd1,
    S_ISSUE_B = 3'd2,
    S_DRAIN   = 3'd3,
    S_OUT     = 3'd4
  } seq_state_t;

  function automatic logic needs_r2(input logic [1:0] rsel);
    return (rsel == RSEL_BOTH) || (rsel == RSEL_R2);
  endfunction

  function automatic logic needs_r3(input logic [1:0] rsel);
    return (rsel == RSEL_BOTH) || (rsel == RSEL_R3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vreg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : vreg_scoreboard
// Description : One pending-write bit per vector register. Set on dispatch,
//               cleared on writeback (set wins on a same-address collision).
//               Hazard query looks at the registered bits only.
// Ports       : clk, rst_n           - clock, async active-low reset
//               set_i / set_addr_i   - mark register pending
//               clr_i / clr_addr_i   - writeback clears pending bit
//               chk_*_i / *_addr_i   - operands/destination to check
//               hazard_o             - any checked register is pending
// Revision    : 1.0 - initial release
// ============================================================================
module vreg_scoreboard
  import ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic              chk_r2_i,
  input  logic [ADDR_W-1:0] r2_addr_i,
  input  logic              chk_r3_i,
  input  logic [ADDR_W-1:0] r3_addr_i,
  input  logic              chk_rd_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              hazard_o
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  // Clear applied first so a simultaneous set of the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d[clr_addr_i] = 1'b0;
    if (set_i) pend_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign hazard_o = (chk_r2_i & pend_q[r2_addr_i])
                  | (chk_r3_i & pend_q[r3_addr_i])
                  | (chk_rd_i & pend_q[rd_addr_i]);

endmodule
`default_nettype wire

// File: rtl/vreg_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vreg_read_sequencer
// Description : Issue-stage controller. Accepts one decoded instruction,
//               waits out RAW/WAW hazards, reads R2/R3 through the single
//               register-file read port (one read per cycle, 1-cycle RAM
//               latency) and presents the operand bundle on valid/ready.
// Ports       : in_*          - decoded instruction, valid/ready
//               rf_rd_*       - register file read port
//               wb_valid/addr - writeback notification (clears pending)
//               out_*         - operand bundle, valid/ready
//               stall_cycles  - saturating hazard-stall counter
// Revision    : 1.0 - initial release
// ============================================================================
module vreg_read_sequencer
  import ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OPC_W   = DEF_OPC_W,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPC_W-1:0]   in_opcode,
  input  logic [1:0]         in_rsel,
  input  logic [ADDR_W-1:0]  in_r2_addr,
  input  logic [ADDR_W-1:0]  in_r3_addr,
  input  logic [ADDR_W-1:0]  in_rd_addr,
  input  logic               in_wr_en,
  output logic               rf_rd_en,
  output logic [ADDR_W-1:0]  rf_rd_addr,
  input  logic [DATA_W-1:0]  rf_rd_data,
  input  logic               wb_valid,
  input  logic [ADDR_W-1:0]  wb_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [DATA_W-1:0]  out_op2,
  output logic [DATA_W-1:0]  out_op3,
  output logic [ADDR_W-1:0]  out_rd_addr,
  output logic               out_wr_en,
  output logic [STALL_W-1:0] stall_cycles
);

  seq_state_t          state_q, state_d;
  logic [OPC_W-1:0]    opcode_q, opcode_d;
  logic [1:0]          rsel_q, rsel_d;
  logic [ADDR_W-1:0]   r2_q, r2_d;
  logic [ADDR_W-1:0]   r3_q, r3_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [DATA_W-1:0]   op3_q, op3_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                sb_set;
  logic                hazard;

  vreg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (sb_set),
    .set_addr_i (rd_q),
    .clr_i      (wb_valid),
    .clr_addr_i (wb_addr),
    .chk_r2_i   (needs_r2(rsel_q)),
    .r2_addr_i  (r2_q),
    .chk_r3_i   (needs_r3(rsel_q)),
    .r3_addr_i  (r3_q),
    .chk_rd_i   (wr_en_q),
    .rd_addr_i  (rd_q),
    .hazard_o   (hazard)
  );

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    rsel_d     = rsel_q;
    r2_d       = r2_q;
    r3_d       = r3_q;
    rd_d       = rd_q;
    wr_en_d    = wr_en_q;
    op2_d      = op2_q;
    op3_d      = op3_q;
    stall_d    = stall_q;
    in_ready   = 1'b0;
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;
    sb_set     = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          opcode_d = in_opcode;
          rsel_d   = in_rsel;
          r2_d     = in_r2_addr;
          r3_d     = in_r3_addr;
          rd_d     = in_rd_addr;
          wr_en_d  = in_wr_en;
          op2_d    = '0;
          op3_d    = '0;
          state_d  = S_ISSUE_A;
        end
      end
      S_ISSUE_A: begin
        if (hazard) begin
          if (stall_q != {STALL_W{1'b1}}) stall_d = stall_q + 1'b1;
        end else begin
          case (rsel_q)
            RSEL_NONE: state_d = S_OUT;
            RSEL_R2: begin
              rf_rd_en   = 1'b1;
              rf_rd_addr = r2_q;
              state_d    = S_DRAIN;
            end
            RSEL_R3: begin
              rf_rd_en   = 1'b1;
              rf_rd_addr = r3_q;
              state_d    = S_DRAIN;
            end
            default: begin
              rf_rd_en   = 1'b1;
              rf_rd_addr = r2_q;
              state_d    = S_ISSUE_B;
            end
          endcase
        end
      end
      S_ISSUE_B: begin
        op2_d      = rf_rd_data;
        rf_rd_en   = 1'b1;
        rf_rd_addr = r3_q;
        state_d    = S_DRAIN;
      end
      S_DRAIN: begin
        // Only the R2-only case ends on an R2 read; every other read path ends on R3.
        if (rsel_q == RSEL_R2) op2_d = rf_rd_data;
        else                   op3_d = rf_rd_data;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          sb_set  = wr_en_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      rsel_q   <= '0;
      r2_q     <= '0;
      r3_q     <= '0;
      rd_q     <= '0;
      wr_en_q  <= 1'b0;
      op2_q    <= '0;
      op3_q    <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      rsel_q   <= rsel_d;
      r2_q     <= r2_d;
      r3_q     <= r3_d;
      rd_q     <= rd_d;
      wr_en_q  <= wr_en_d;
      op2_q    <= op2_d;
      op3_q    <= op3_d;
      stall_q  <= stall_d;
    end
  end

  assign out_valid    = (state_q == S_OUT);
  assign out_opcode   = opcode_q;
  assign out_op2      = op2_q;
  assign out_op3      = op3_q;
  assign out_rd_addr  = rd_q;
  assign out_wr_en    = wr_en_q;
  assign stall_cycles = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_vreg_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vreg_read_sequencer
// Description : Self-checking bench for vreg_read_sequencer with a register
//               file model and an expected-bundle queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vreg_read_sequencer;
  import ctrl_pkg::*;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 128;
  localparam int OPC_W   = 5;
  localparam int STALL_W = 16;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [OPC_W-1:0]   in_opcode;
  logic [1:0]         in_rsel;
  logic [ADDR_W-1:0]  in_r2_addr;
  logic [ADDR_W-1:0]  in_r3_addr;
  logic [ADDR_W-1:0]  in_rd_addr;
  logic               in_wr_en;
  logic               rf_rd_en;
  logic [ADDR_W-1:0]  rf_rd_addr;
  logic [DATA_W-1:0]  rf_rd_data;
  logic               wb_valid;
  logic [ADDR_W-1:0]  wb_addr;
  logic               out_valid;
  logic               out_ready;
  logic [OPC_W-1:0]   out_opcode;
  logic [DATA_W-1:0]  out_op2;
  logic [DATA_W-1:0]  out_op3;
  logic [ADDR_W-1:0]  out_rd_addr;
  logic               out_wr_en;
  logic [STALL_W-1:0] stall_cycles;

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] op3;
    logic [ADDR_W-1:0] rd;
    logic              wr;
  } bundle_t;

  bundle_t           exp_q[$];
  logic [DATA_W-1:0] rf_mem [16];
  int                n_checks;
  int                n_fail;
  int                cyc;
  int                acc_cyc;

  vreg_read_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OPC_W(OPC_W), .STALL_W(STALL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rsel(in_rsel), .in_r2_addr(in_r2_addr), .in_r3_addr(in_r3_addr),
    .in_rd_addr(in_rd_addr), .in_wr_en(in_wr_en),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_op2(out_op2), .out_op3(out_op3), .out_rd_addr(out_rd_addr),
    .out_wr_en(out_wr_en), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (rf_rd_en) rf_rd_data <= rf_mem[rf_rd_addr];
  end

  function automatic bundle_t cur_bundle();
    return {out_opcode, out_op2, out_op3, out_rd_addr, out_wr_en};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [OPC_W-1:0] opc, input logic [1:0] rsel,
                       input logic [ADDR_W-1:0] r2, input logic [ADDR_W-1:0] r3,
                       input logic [ADDR_W-1:0] rd, input logic wr);
    bundle_t e;
    in_valid   = 1'b1;
    in_opcode  = opc;
    in_rsel    = rsel;
    in_r2_addr = r2;
    in_r3_addr = r3;
    in_rd_addr = rd;
    in_wr_en   = wr;
    step();
    in_valid = 1'b0;
    acc_cyc  = cyc - 1;
    e.opc = opc;
    e.op2 = (rsel == 2'b00 || rsel == 2'b01) ? rf_mem[r2] : '0;
    e.op3 = (rsel == 2'b00 || rsel == 2'b10) ? rf_mem[r3] : '0;
    e.rd  = rd;
    e.wr  = wr;
    exp_q.push_back(e);
  endtask

  task automatic wait_out(output int lat);
    while (out_valid !== 1'b1 && (cyc - acc_cyc) < 40) step();
    lat = cyc - acc_cyc;
  endtask

  task automatic wb_pulse(input logic [ADDR_W-1:0] a);
    wb_valid = 1'b1;
    wb_addr  = a;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    step();
    n_checks++;
    if (cur_bundle() !== '0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs_held: got %h valid %b, want 0", cur_bundle(), out_valid);
    end
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if ({rf_rd_en, rf_rd_addr} !== 5'h00) begin
      n_fail++; $display("FAIL reset_rf_port: got en %b addr %h want 0/0", rf_rd_en, rf_rd_addr);
    end
    n_checks++;
    if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    n_checks++;
    if (cur_bundle() !== '0) begin n_fail++; $display("FAIL reset_bundle: got %h want 0", cur_bundle()); end
  endtask

  task automatic test_both();
    int lat;
    bundle_t e;
    issue(5'h03, 2'b00, 4'd3, 4'd5, 4'd9, 1'b0);
    n_checks++;
    if ({rf_rd_en, rf_rd_addr} !== {1'b1, 4'd3}) begin
      n_fail++; $display("FAIL both_read1: got en %b addr %0d want 1/3", rf_rd_en, rf_rd_addr);
    end
    step();
    n_checks++;
    if ({rf_rd_en, rf_rd_addr} !== {1'b1, 4'd5}) begin
      n_fail++; $display("FAIL both_read2: got en %b addr %0d want 1/5", rf_rd_en, rf_rd_addr);
    end
    step();
    n_checks++;
    if (rf_rd_en !== 1'b0) begin n_fail++; $display("FAIL both_drain_no_read: got %b want 0", rf_rd_en); end
    wait_out(lat);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL both_latency: got %0d want 4", lat); end
    e = exp_q.pop_front();
    n_checks++;
    if (cur_bundle() !== e) begin n_fail++; $display("FAIL both_bundle: got %h want %h", cur_bundle(), e); end
    step();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL both_back_idle: got ready %b valid %b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_none();
    int lat;
    bundle_t e;
    issue(5'b10001, 2'b11, 4'd3, 4'd5, 4'd2, 1'b0);
    n_checks++;
    if (rf_rd_en !== 1'b0) begin n_fail++; $display("FAIL none_no_read: got %b want 0", rf_rd_en); end
    wait_out(lat);
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL none_latency: got %0d want 2", lat); end
    e = exp_q.pop_front();
    n_checks++;
    if (cur_bundle() !== e) begin n_fail++; $display("FAIL none_bundle: got %h want %h", cur_bundle(), e); end
    step();
  endtask

  task automatic test_single();
    int lat;
    bundle_t e;
    issue(5'h0A, 2'b01, 4'd9, 4'd1, 4'd6, 1'b0);
    n_checks++;
    if ({rf_rd_en, rf_rd_addr} !== {1'b1, 4'd9}) begin
      n_fail++; $display("FAIL r2only_read: got en %b addr %0d want 1/9", rf_rd_en, rf_rd_addr);
    end
    step();
    n_checks++;
    if (rf_rd_en !== 1'b0) begin n_fail++; $display("FAIL r2only_single_read: got %b want 0", rf_rd_en); end
    wait_out(lat);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL r2only_latency: got %0d want 3", lat); end
    e = exp_q.pop_front();
    n_checks++;
    if (cur_bundle() !== e) begin n_fail++; $display("FAIL r2only_bundle: got %h want %h", cur_bundle(), e); end
    step();
    issue(5'h0B, 2'b10, 4'd2, 4'd12, 4'd1, 1'b0);
    n_checks++;
    if ({rf_rd_en, rf_rd_addr} !== {1'b1, 4'd12}) begin
      n_fail++; $display("FAIL r3only_read: got en %b addr %0d want 1/12", rf_rd_en, rf_rd_addr);
    end
    wait_out(lat);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL r3only_latency: got %0d want 3", lat); end
    e = exp_q.pop_front();
    n_checks++;
    if (cur_bundle() !== e) begin n_fail++; $display("FAIL r3only_bundle: got %h want %h", cur_bundle(), e); end
    step();
  endtask

  task automatic test_hazard();
    int lat;
    bundle_t e;
    logic bad;
    logic [STALL_W-1:0] s0;
    issue(5'h01, 2'b11, 4'd0, 4'd0, 4'd7, 1'b1);
    wait_out(lat);
    e = exp_q.pop_front();
    n_checks++;
    if (cur_bundle() !== e) begin n_fail++; $display("FAIL hazA_bundle: got %h want %h", cur_bundle(), e); end
    step();
    s0 = stall_cycles;
    issue(5'h02, 2'b01, 4'd7, 4'd0, 4'd0, 1'b0);
    bad = rf_rd_en | out_valid;
    repeat (4) begin
      step();
      bad = bad | rf_rd_en | out_valid;
    end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL hazB_stalled: got activity %b want 0", bad); end
    wb_pulse(4'd7);
    n_checks++;
    if ({rf_rd_en, rf_rd_addr} !== {1'b1, 4'd7}) begin
      n_fail++; $display("FAIL hazB_read_after_wb: got en %b addr %0d want 1/7", rf_rd_en, rf_rd_addr);
    end
    n_checks++;
    if (stall_cycles - s0 !== 16'd5) begin
      n_fail++; $display("FAIL hazB_stall_count: got %0d want 5", stall_cycles - s0);
    end
    wait_out(lat);
    n_checks++;
    if (lat != 8) begin n_fail++; $display("FAIL hazB_latency: got %0d want 8", lat); end
    e = exp_q.pop_front();
    n_checks++;
    if (cur_bundle() !== e) begin n_fail++; $display("FAIL hazB_bundle: got %h want %h", cur_bundle(), e); end
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    bundle_t e;
    bundle_t snap;
    logic bad;
    out_ready = 1'b0;
    issue(5'h04, 2'b00, 4'd1, 4'd2, 4'd3, 1'b0);
    wait_out(lat);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL bp_latency: got %0d want 4", lat); end
    snap = cur_bundle();
    bad  = 1'b0;
    repeat (5) begin
      step();
      bad = bad | (cur_bundle() !== snap) | in_ready | rf_rd_en | ~out_valid;
    end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL bp_hold_stable: got violation %b want 0", bad); end
    e = exp_q.pop_front();
    n_checks++;
    if (cur_bundle() !== e) begin n_fail++; $display("FAIL bp_bundle: got %h want %h", cur_bundle(), e); end
    out_ready = 1'b1;
    step();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL bp_release_idle: got ready %b valid %b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_set_clear();
    int lat;
    bundle_t e;
    logic [STALL_W-1:0] s0;
    out_ready = 1'b0;
    issue(5'h06, 2'b11, 4'd0, 4'd0, 4'd7, 1'b1);
    wait_out(lat);
    e = exp_q.pop_front();
    n_checks++;
    if (cur_bundle() !== e) begin n_fail++; $display("FAIL sc_first_bundle: got %h want %h", cur_bundle(), e); end
    out_ready = 1'b1;
    wb_pulse(4'd7);
    s0 = stall_cycles;
    issue(5'h07, 2'b01, 4'd7, 4'd0, 4'd0, 1'b0);
    repeat (3) step();
    n_checks++;
    if (stall_cycles - s0 !== 16'd3 || rf_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL sc_set_wins: got stalls %0d en %b want 3/0", stall_cycles - s0, rf_rd_en);
    end
    wb_pulse(4'd7);
    wait_out(lat);
    n_checks++;
    if (lat != 7) begin n_fail++; $display("FAIL sc_latency: got %0d want 7", lat); end
    e = exp_q.pop_front();
    n_checks++;
    if (cur_bundle() !== e) begin n_fail++; $display("FAIL sc_bundle: got %h want %h", cur_bundle(), e); end
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    bundle_t e;
    issue(5'h08, 2'b11, 4'd0, 4'd0, 4'd7, 1'b1);
    wait_out(lat);
    void'(exp_q.pop_front());
    step();
    issue(5'h09, 2'b00, 4'd3, 4'd5, 4'd2, 1'b0);
    step();
    n_checks++;
    if ({rf_rd_en, rf_rd_addr} !== {1'b1, 4'd5}) begin
      n_fail++; $display("FAIL mid_in_issue_b: got en %b addr %0d want 1/5", rf_rd_en, rf_rd_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (cur_bundle() !== '0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_outputs_cleared: got %h valid %b want 0", cur_bundle(), out_valid);
    end
    n_checks++;
    if ({rf_rd_en, rf_rd_addr} !== 5'h00) begin
      n_fail++; $display("FAIL mid_rf_port: got en %b addr %h want 0/0", rf_rd_en, rf_rd_addr);
    end
    n_checks++;
    if (stall_cycles !== 16'd0) begin n_fail++; $display("FAIL mid_stall_cleared: got %0d want 0", stall_cycles); end
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    issue(5'h0C, 2'b01, 4'd7, 4'd0, 4'd0, 1'b0);
    wait_out(lat);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL mid_sb_cleared_latency: got %0d want 3", lat); end
    e = exp_q.pop_front();
    n_checks++;
    if (cur_bundle() !== e) begin n_fail++; $display("FAIL mid_bundle: got %h want %h", cur_bundle(), e); end
    step();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    acc_cyc    = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_opcode  = '0;
    in_rsel    = '0;
    in_r2_addr = '0;
    in_r3_addr = '0;
    in_rd_addr = '0;
    in_wr_en   = 1'b0;
    wb_valid   = 1'b0;
    wb_addr    = '0;
    out_ready  = 1'b1;
    rf_rd_data = '0;
    for (int i = 0; i < 16; i++) rf_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    rf_mem[3] = {16{8'hAA}};
    rf_mem[5] = {16{8'h55}};

    test_reset();
    test_both();
    test_none();
    test_single();
    test_hazard();
    test_backpressure();
    test_set_clear();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vreg_read_sequencer.md
Name: vreg_read_sequencer

Overview:
- Issue-stage controller for the vector ASIP. It takes one decoded instruction at a time, together with the 2-bit register-read select produced by the read-select decoder.
- It shares the single read port of the vector register file across the R2 and R3 operand reads, one read per cycle.
- It stalls on RAW/WAW hazards using a write scoreboard. It hands the complete operand bundle to the execute stage over a valid/ready handshake.

Parameters:
- ADDR_W, 4, vector register address width (NREGS = 2**ADDR_W = 16)
- DATA_W, 128, vector register width in bits
- OPC_W, 5, opcode width
- STALL_W, 16, width of the stall performance counter

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low)
- in_valid  in  1  decoded instruction available
- in_ready  out  1  sequencer can accept an instruction
- in_opcode  in  OPC_W  opcode
- in_rsel  in  2  read select: 00 both, 01 R2 only, 10 R3 only, 11 none
- in_r2_addr  in  ADDR_W  source R2 address
- in_r3_addr  in  ADDR_W  source R3 address
- in_rd_addr  in  ADDR_W  destination address
- in_wr_en  in  1  instruction writes rd
- rf_rd_en  out  1  register file read strobe
- rf_rd_addr  out  ADDR_W  register file read address
- rf_rd_data  in  DATA_W  read data, valid on the cycle after rf_rd_en (1-cycle synchronous RAM)
- wb_valid  in  1  writeback completes this cycle
- wb_addr  in  ADDR_W  writeback register
- out_valid  out  1  operand bundle valid
- out_ready  in  1  execute stage accepts bundle
- out_opcode  out  OPC_W  latched opcode
- out_op2  out  DATA_W  R2 operand; 0 if not read
- out_op3  out  DATA_W  R3 operand; 0 if not read
- out_rd_addr  out  ADDR_W  latched rd
- out_wr_en  out  1  latched wr_en
- stall_cycles  out  STALL_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; scoreboard all 0.
  - All out_* = 0; rf_rd_en = 0, rf_rd_addr = 0; stall_cycles = 0.
  - in_ready is 1 in the first cycle after reset release.
  - Reset mid-operation drops the in-flight instruction and clears the scoreboard.
- FSM states: IDLE, ISSUE_A, ISSUE_B, DRAIN, OUT.
- IDLE:
  - in_ready = 1 (asserted only in IDLE).
  - On in_valid: latch all in_* fields; op2/op3 regs cleared to 0; go to ISSUE_A.
- ISSUE_A, hazard check:
  - hazard = (needs R2 & pend[r2]) | (needs R3 & pend[r3]) | (wr_en & pend[rd]).
  - Uses registered scoreboard only; a writeback becomes visible the following cycle.
  - If hazard: stay in ISSUE_A, rf_rd_en = 0, stall_cycles += 1 (saturate at all-ones).
  - Else by rsel:
    - 11: go to OUT.
    - 01: read r2, go to DRAIN.
    - 10: read r3, go to DRAIN.
    - 00: read r2, go to ISSUE_B.
- ISSUE_B: capture rf_rd_data into op2; read r3; go to DRAIN.
- DRAIN: capture rf_rd_data into the operand of the last read (op3 if R3 was the last read, else op2); go to OUT.
- OUT:
  - out_valid = 1; outputs stable while out_ready = 0.
  - On out_ready: if wr_en set pend[rd]; go to IDLE.
- Scoreboard:
  - wb_valid clears pend[wb_addr] at the edge.
  - Set and clear of the same address in the same cycle: set wins.
  - wb to a non-pending register is ignored.
- Latency from the accept edge to out_valid with no hazard: rsel 11 → 2 cycles, 01/10 → 3, 00 → 4. Each hazard-stall cycle adds 1.
- rf_rd_en is never high in two consecutive cycles except ISSUE_A→ISSUE_B.

Decomposition:
- Shared package ctrl_pkg holds:
  - RSEL_BOTH/RSEL_R2/RSEL_R3/RSEL_NONE constants
  - seq_state_t enum
  - ADDR_W/DATA_W/OPC_W defaults
- Sub-module vreg_scoreboard holds the pending bits, the set/clear ports and a combinational hazard query.

Test Plan:
- Reset with rsel=00, r2=3, r3=5, rf[3]=0xAA.., rf[5]=0x55.. → rf_rd_addr 3 then 5 on consecutive cycles; out_valid on cycle 4 with op2=0xAA.., op3=0x55...
- rsel=11 (opcode 10001) → no rf_rd_en; out_valid on cycle 2 with op2=op3=0.
- Instr A (wr_en, rd=7) accepted, then instr B with rsel=01, r2=7 → B stalls in ISSUE_A until the cycle after wb_valid addr 7; stall_cycles equals the stall length.
- out_ready held 0 for 5 cycles in OUT → outputs stable, in_ready=0, no new reads; release → IDLE next cycle.
- wb_valid addr 7 in the same cycle that dispatch sets pend[7] → pend[7]=1 afterwards.
- rst_n pulsed low while in ISSUE_B → outputs 0 immediately, scoreboard cleared, in_ready=1 after release.
